// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader and its helpers.
package mips_pkg;

    localparam int INSTR_W   = 32;
    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } ld_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Big-endian 4-byte shift assembler: each accepted byte shifts in at the
// bottom, and the 4th byte raises word_valid_o together with the full word.
module byte_word_packer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [7:0]         data_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_valid_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // The word is complete as the 4th byte is presented, so the caller can
    // register it on the same edge that consumes the byte.
    assign word_o       = {shift_q, data_i};
    assign word_valid_o = en_i && (cnt_q == 2'd3);

    // Shift register and byte counter; a clear discards any partial word.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst || clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (en_i) begin
            shift_q <= word_o[23:0];
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream: 16-bit big-endian word
// count followed by that many big-endian 32-bit words. The system top holds
// the core in reset with (rst | cpu_hold) and muxes im_we/im_addr/im_wdata
// onto the instruction-memory write port while the load runs.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int DEPTH = 2 ** ADDR_W;

    ld_state_e          state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        widx_q, widx_d;
    logic               im_we_q, im_we_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [INSTR_W-1:0] im_wdata_q, im_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               last_q, last_d;   // final word's write cycle

    logic               xfer;
    logic               pack_clr;
    logic               pack_en;
    logic [INSTR_W-1:0] pack_word;
    logic               pack_valid;
    logic [15:0]        hdr_n;
    logic               in_range;

    assign busy     = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                      (state_q == ST_DATA);
    assign in_ready = busy;
    assign xfer     = in_valid && in_ready;
    assign pack_en  = xfer && (state_q == ST_DATA);
    assign hdr_n    = {count_q[15:8], in_data};
    // Words past the end of memory are consumed but never written.
    assign in_range = 32'(widx_q) < DEPTH;

    byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (pack_clr),
        .en_i         (pack_en),
        .data_i       (in_data),
        .word_o       (pack_word),
        .word_valid_o (pack_valid)
    );

    // Next-state and next-output logic for the load sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        widx_d     = widx_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        last_d     = 1'b0;
        pack_clr   = 1'b0;

        // One cycle after the final write strobe, release the core.
        if (last_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_HDR_HI;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    widx_d     = '0;
                    cpu_hold_d = 1'b1;
                    pack_clr   = 1'b1;
                end
            end
            ST_HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = in_data;
                    state_d       = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                        if (32'(hdr_n) > DEPTH) err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (pack_valid) begin
                    im_we_d = in_range;
                    if (in_range) begin
                        im_addr_d  = widx_q[ADDR_W-1:0];
                        im_wdata_d = pack_word;
                    end
                    widx_d = widx_q + 16'd1;
                    if (widx_q == count_q - 16'd1) begin
                        state_d = ST_DONE;
                        last_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            widx_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_q     <= last_d;
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (256-word and 4-word memories) share
// one byte stream; writes are collected and compared with expected images.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;

    logic        b_in_ready, b_im_we, b_cpu_hold, b_busy, b_done, b_err;
    logic [7:0]  b_im_addr;
    logic [31:0] b_im_wdata;
    logic        s_in_ready, s_im_we, s_cpu_hold, s_busy, s_done, s_err;
    logic [1:0]  s_im_addr;
    logic [31:0] s_im_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(b_in_ready), .im_we(b_im_we),
        .im_addr(b_im_addr), .im_wdata(b_im_wdata), .cpu_hold(b_cpu_hold),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    imem_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(s_in_ready), .im_we(s_im_we),
        .im_addr(s_im_addr), .im_wdata(s_im_wdata), .cpu_hold(s_cpu_hold),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq_b[$];
    wr_t         wq_s[$];
    logic [31:0] img[6];

    // Write-port monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (b_im_we) wq_b.push_back({b_im_addr, b_im_wdata});
        if (s_im_we) wq_s.push_back({6'd0, s_im_addr, s_im_wdata});
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: writes land at 0..min(N,DEPTH)-1, err iff N > DEPTH.
    function automatic int exp_writes(input int n, input int depth);
        return (n < depth) ? n : depth;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit st, output bit ok);
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        start    = st;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (b_in_ready && s_in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // gap < 0 selects a random 0..2 idle cycles between bytes.
    task automatic run_load(input int n, input int gap, input int start_at);
        logic [7:0]  bytes[$];
        logic [15:0] n16;
        logic [31:0] w;
        bit          ok;
        int          nacc;
        nacc = 0;
        n16  = 16'(n);
        bytes.push_back(n16[15:8]);
        bytes.push_back(n16[7:0]);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int j = 3; j >= 0; j--) bytes.push_back(w[8*j +: 8]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_after_start", b_cpu_hold, 1);
        check("busy_after_start", b_busy, 1);
        check("done_cleared", b_done, 0);
        wq_b.delete();
        wq_s.delete();
        for (int k = 0; k < bytes.size(); k++) begin
            send_byte(bytes[k], k == start_at, ok);
            if (ok) nacc++;
            if (k == 1) begin
                check("err_after_hdr_s", s_err, (n > 4) ? 1 : 0);
                check("err_after_hdr_b", b_err, 0);
            end
            if (k != bytes.size() - 1)
                repeat ((gap < 0) ? $urandom_range(0, 2) : gap) tick();
        end
        check("bytes_accepted", nacc, bytes.size());
        if (n == 0) begin
            check("empty_done", b_done, 1);
            check("empty_hold", b_cpu_hold, 0);
            check("empty_ready", b_in_ready, 0);
        end else begin
            check("last_we", b_im_we, 1);
            check("done_not_early", b_done, 0);
            tick();
            check("done_after_we", b_done, 1);
            check("hold_release", b_cpu_hold, 0);
            check("we_single", b_im_we, 0);
        end
        tick();
        tick();
    endtask

    task automatic check_result(input int n, input bit eeb, input bit ees);
        int wb;
        int ws;
        wb = exp_writes(n, 256);
        ws = exp_writes(n, 4);
        check("wr_count_b", wq_b.size(), wb);
        check("wr_count_s", wq_s.size(), ws);
        for (int i = 0; i < wb && i < wq_b.size(); i++)
            check("wr_b", wq_b[i], {8'(i), img[i]});
        for (int i = 0; i < ws && i < wq_s.size(); i++)
            check("wr_s", wq_s[i], {8'(i), img[i]});
        check("err_b", b_err, eeb);
        check("err_s", s_err, ees);
        check("done_b", b_done, 1);
        check("done_s", s_done, 1);
        check("ready_idle", b_in_ready, 0);
    endtask

    typedef struct {
        int n;
        int gap;
        int start_at;
        bit exp_err_b;
        bit exp_err_s;
    } vec_t;

    initial begin
        vec_t vecs[6];
        bit   ok;
        int   n;

        vecs[0] = '{2,  0, -1, 1'b0, 1'b0};  // basic back-to-back
        vecs[1] = '{2,  3, -1, 1'b0, 1'b0};  // 3-cycle stalls
        vecs[2] = '{0,  0, -1, 1'b0, 1'b0};  // empty image
        vecs[3] = '{6,  0, -1, 1'b0, 1'b1};  // overflows the 4-word memory
        vecs[4] = '{3,  1,  5, 1'b0, 1'b0};  // start pulsed during DATA
        vecs[5] = '{5, -1, -1, 1'b0, 1'b1};  // random gaps, overflow

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check("reset_b", {b_in_ready, b_im_we, b_im_addr, b_im_wdata,
                          b_cpu_hold, b_busy, b_done, b_err}, 0);
        check("reset_s", {s_in_ready, s_im_we, s_im_addr, s_im_wdata,
                          s_cpu_hold, s_busy, s_done, s_err}, 0);
        rst = 1'b0;
        tick();

        img[0] = 32'h2008_0005;
        img[1] = 32'h2009_000A;
        img[2] = 32'h8C0A_0000;
        img[3] = 32'hAC0B_0004;
        img[4] = 32'h0109_5020;
        img[5] = 32'h1000_FFFF;
        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].n, vecs[v].gap, vecs[v].start_at);
            check_result(vecs[v].n, vecs[v].exp_err_b, vecs[v].exp_err_s);
        end

        // Reset in the middle of word 1, then a fresh single-word load.
        img[0] = 32'h1122_3344;
        img[1] = 32'h5566_7788;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h02, 1'b0, ok);
        send_byte(8'h11, 1'b0, ok);
        send_byte(8'h22, 1'b0, ok);
        send_byte(8'h33, 1'b0, ok);
        send_byte(8'h44, 1'b0, ok);
        send_byte(8'h55, 1'b0, ok);
        send_byte(8'h66, 1'b0, ok);
        rst = 1'b1;
        tick();
        check("midword_rst_b", {b_in_ready, b_im_we, b_im_addr, b_im_wdata,
                                b_cpu_hold, b_busy, b_done, b_err}, 0);
        check("midword_rst_s", {s_in_ready, s_im_we, s_im_addr, s_im_wdata,
                                s_cpu_hold, s_busy, s_done, s_err}, 0);
        rst = 1'b0;
        img[0] = 32'h8C0A_0000;
        run_load(1, 0, -1);
        check_result(1, 1'b0, 1'b0);

        // Random images against the reference model.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < 6; i++) img[i] = $urandom;
            run_load(n, -1, -1);
            check_result(n, 1'b0, n > 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Synthesizable program loader that writes the instruction memory of the MIPS `Processor` from a byte stream. It replaces simulation-only `$readmemh` preloading on hardware. It sits between a byte source (UART receiver or debug host) and the instruction-memory write port. It holds the core in reset while loading and releases it when the image is complete.

## Interface

**Parameters**
- `ADDR_W`, 8: instruction-memory word-address width; depth `DEPTH = 2**ADDR_W` words.

**Ports**
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a load; sampled only in IDLE or DONE.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle; a transfer occurs when `in_valid & in_ready`.
- `im_we` out 1: one-cycle instruction-memory write strobe.
- `im_addr` out ADDR_W: word address for the write.
- `im_wdata` out 32: instruction word for the write.
- `cpu_hold` out 1: keeps the processor in reset while high.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load completed; sticky until the next `start` or `rst`.
- `err` out 1: the header count exceeded `DEPTH`; sticky until the next `start` or `rst`.

## Operation

**Stream format:** a 16-bit word count N, big-endian (high byte first), followed by N 32-bit instructions, each big-endian. This byte order matches the hex-word order of `.bin` program files.

**States:** IDLE, HDR_HI, HDR_LO, DATA, DONE.
- IDLE/DONE + `start` → HDR_HI. On this transition: clear `done` and `err`, set word index and byte counter to 0, assert `cpu_hold`.
- HDR_HI + transfer → HDR_LO. Latch `count[15:8]`.
- HDR_LO + transfer → latch `count[7:0]`, then:
  - if N = 0, go to DONE;
  - otherwise go to DATA, and set `err` if N > `DEPTH`.
- DATA + transfer → shift the byte into the word assembler (`word = {word[23:0], in_data}`) and increment the byte counter (2 bits, wraps).
  - On the 4th byte, on the next cycle: pulse `im_we` with `im_addr` = word index and `im_wdata` = the assembled word. Then increment the word index.
  - Write suppression: if word index ≥ `DEPTH`, the bytes are still consumed but `im_we` stays low and `im_addr` does not wrap.
  - After the Nth word's 4th byte → DONE.
- DONE: `done` = 1, `cpu_hold` = 0, `in_ready` = 0.

**Other rules:**
- `in_ready` = 1 exactly in HDR_HI, HDR_LO and DATA.
- `busy` = 1 exactly in HDR_HI, HDR_LO and DATA.
- `start` is ignored while `busy`.
- `in_valid` is ignored outside HDR_HI, HDR_LO and DATA.
- `rst` at any time, including mid-word:
  - state → IDLE;
  - all outputs → 0;
  - a partial word is discarded;
  - memory words already written are left unchanged.
- Reset values: `in_ready`, `im_we`, `im_addr`, `im_wdata`, `cpu_hold`, `busy`, `done` and `err` are all 0.

## Timing

- Byte acceptance has zero-cycle latency. The loader sustains one byte per cycle and tolerates arbitrary `in_valid` gaps.
- `im_we`, `im_addr` and `im_wdata` are registered. They are valid the cycle after the 4th byte's transfer.
- `cpu_hold` rises the cycle after `start` is sampled.
- `done` rises and `cpu_hold` falls together:
  - the cycle after the last `im_we` pulse when the last word was written;
  - the cycle after the HDR_LO transfer when N = 0.
- With a gap-free stream, the minimum load time is 2 + 4N cycles plus 1 cycle to DONE.
- `err` rises the cycle after the HDR_LO transfer.

## Structure

- Shared package `mips_pkg` holds:
  - the state encoding constants (IDLE=0, HDR_HI=1, HDR_LO=2, DATA=3, DONE=4);
  - `INSTR_W = 32`;
  - `HDR_BYTES = 2`.
- Sub-module `byte_word_packer`: 4-byte shift assembler with a 2-bit counter. Outputs `word` and a `word_valid` pulse, and has a synchronous clear. The FSM stays in `imem_loader`.
- Top-level integration: drive the `Processor` reset as `rst | cpu_hold`, and mux `im_we`, `im_addr` and `im_wdata` into the instruction-memory write port.

## Test plan

1. **Basic load.** Stimulus: `start`, then bytes `00 02 20 08 00 05 20 09 00 0A`, back-to-back. Required response:
   - `im_we` at addr 0 with `20080005`;
   - `im_we` at addr 1 with `2009000A`;
   - `done` = 1 and `cpu_hold` = 0 one cycle after the second write;
   - `err` = 0.
2. **Stalled stream.** Stimulus: same image, with `in_valid` low for 3 cycles between every byte. Required response: identical writes in the same order, with no extra or missing `im_we` pulses.
3. **Empty image.** Stimulus: header `00 00`. Required response: no `im_we`; `done` = 1 the cycle after the second header byte; `in_ready` = 0 afterwards.
4. **Overflow.** Stimulus: `ADDR_W` = 2, header `00 06`, 24 data bytes. Required response:
   - `err` = 1 after the header;
   - exactly 4 writes, at addr 0–3;
   - all 24 bytes accepted;
   - `done` = 1.
5. **Reset mid-word.** Stimulus: `rst` pulsed after 2 bytes of word 1, then a fresh 1-word load of `8C0A0000`. Required response:
   - all outputs 0 the cycle after `rst`;
   - the new write goes to addr 0 with `8C0A0000`.
6. **Start while busy.** Stimulus: `start` pulsed during DATA. Required response: ignored; the load completes with the original N and the original word indices.
